// File: rtl/rv_pipe_pkg.sv
// Shared pipeline encodings: operand-forwarding selects and the execute-stage
// multi-cycle FSM state type.
package rv_pipe_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_e;

   // The memory stage holds the younger result, so it wins over writeback.
   function automatic fwd_sel_e fwd_pick(input logic m_hit, input logic w_hit);
      if (m_hit) begin
         return FWD_M;
      end else if (w_hit) begin
         return FWD_W;
      end else begin
         return FWD_NONE;
      end
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline is the master; the
// hazard unit is the slave that answers with stall, flush and forward controls.
interface hazard_unit_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic [REG_AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E;
   logic [REG_AW-1:0] rd_E, rd_M, rd_W;
   logic              reg_wr_E, reg_wr_M, reg_wr_W;
   logic              rd_en_E, br_taken_E, mdu_start_E, cnt_clr;
   logic              stall_F, stall_D, stall_E;
   logic              flush_D, flush_E, flush_M;
   logic [1:0]        fwd_a_E, fwd_b_E;
   logic              mdu_done_E;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   modport master (
      output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
      output reg_wr_E, reg_wr_M, reg_wr_W, rd_en_E, br_taken_E, mdu_start_E, cnt_clr,
      input  stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
      input  fwd_a_E, fwd_b_E, mdu_done_E, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
      input  reg_wr_E, reg_wr_M, reg_wr_W, rd_en_E, br_taken_E, mdu_start_E, cnt_clr,
      output stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
      output fwd_a_E, fwd_b_E, mdu_done_E, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: forwarding selects, load-use / RAW stalls,
// branch flushes, multi-cycle execute sequencing and stall/flush counters.
module hazard_unit
   import rv_pipe_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MDU_LAT = 4,
   parameter int FWD_EN  = 1,
   parameter int CNT_W   = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_unit_if.slave hz
);
   localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

   mdu_state_e    state_q;
   logic [CW-1:0] cnt_q;

   logic     hit_m_a, hit_w_a, hit_m_b, hit_w_b;
   logic     load_use, raw_d, data_haz;
   logic     mdu_stall, mdu_done, br_ok, data_stall;
   fwd_sel_e fwd_a, fwd_b;

   // x0 is never a real producer, so it never creates a hazard.
   function automatic logic hit(input logic [REG_AW-1:0] rd, input logic wr,
                                input logic [REG_AW-1:0] rs);
      return wr && (rd != '0) && (rd == rs);
   endfunction

   // Hazard detection and priority between branch, multi-cycle and data stalls.
   always_comb begin
      hit_m_a  = hit(hz.rd_M, hz.reg_wr_M, hz.rs1_E);
      hit_w_a  = hit(hz.rd_W, hz.reg_wr_W, hz.rs1_E);
      hit_m_b  = hit(hz.rd_M, hz.reg_wr_M, hz.rs2_E);
      hit_w_b  = hit(hz.rd_W, hz.reg_wr_W, hz.rs2_E);
      load_use = hz.rd_en_E && (hit(hz.rd_E, hz.reg_wr_E, hz.rs1_D) ||
                                hit(hz.rd_E, hz.reg_wr_E, hz.rs2_D));
      raw_d    = hit(hz.rd_E, hz.reg_wr_E, hz.rs1_D) || hit(hz.rd_E, hz.reg_wr_E, hz.rs2_D) ||
                 hit(hz.rd_M, hz.reg_wr_M, hz.rs1_D) || hit(hz.rd_M, hz.reg_wr_M, hz.rs2_D) ||
                 hit(hz.rd_W, hz.reg_wr_W, hz.rs1_D) || hit(hz.rd_W, hz.reg_wr_W, hz.rs2_D);
      data_haz = (FWD_EN != 0) ? load_use : raw_d;

      mdu_stall = ((state_q == IDLE) && hz.mdu_start_E && (MDU_LAT > 1)) ||
                  ((state_q == BUSY) && (cnt_q != '0));
      mdu_done  = ((state_q == IDLE) && hz.mdu_start_E && (MDU_LAT == 1)) ||
                  ((state_q == BUSY) && (cnt_q == '0));

      // A held multi-cycle op freezes E, so a branch there is not yet resolved.
      br_ok      = hz.br_taken_E && !mdu_stall;
      data_stall = data_haz && !br_ok && !mdu_stall;

      if (FWD_EN != 0) begin
         fwd_a = fwd_pick(hit_m_a, hit_w_a);
         fwd_b = fwd_pick(hit_m_b, hit_w_b);
      end else begin
         fwd_a = FWD_NONE;
         fwd_b = FWD_NONE;
      end
   end

   // Control outputs, forced quiet while reset is asserted.
   always_comb begin
      if (!rst) begin
         hz.stall_F    = 1'b0;
         hz.stall_D    = 1'b0;
         hz.stall_E    = 1'b0;
         hz.flush_D    = 1'b0;
         hz.flush_E    = 1'b0;
         hz.flush_M    = 1'b0;
         hz.fwd_a_E    = FWD_NONE;
         hz.fwd_b_E    = FWD_NONE;
         hz.mdu_done_E = 1'b0;
      end else begin
         hz.stall_F    = data_stall || mdu_stall;
         hz.stall_D    = data_stall || mdu_stall;
         hz.stall_E    = mdu_stall;
         hz.flush_D    = br_ok;
         hz.flush_E    = br_ok || data_stall;
         hz.flush_M    = mdu_stall;
         hz.fwd_a_E    = fwd_a;
         hz.fwd_b_E    = fwd_b;
         hz.mdu_done_E = mdu_done;
      end
   end

   // Multi-cycle execute sequencer; the counter reaches zero on the done cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hz.mdu_start_E && (MDU_LAT > 1)) begin
                  state_q <= BUSY;
                  cnt_q   <= (MDU_LAT > 1) ? CW'(MDU_LAT - 2) : '0;
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (hz.stall_D),
      .clr_i (hz.cnt_clr),
      .cnt_o (hz.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (hz.flush_D || hz.flush_E),
      .clr_i (hz.cnt_clr),
      .cnt_o (hz.flush_cnt)
   );
endmodule
